// File: rtl/iter_mul_seq.sv
// Iterative multiply sequencer: computes n! or b^e by issuing repeated multiply
// operations to a shared, registered ALU and collecting each product.
module iter_mul_seq #(
  parameter int unsigned W          = 16,
  parameter int unsigned NW         = 9,
  parameter int unsigned ALU_LAT    = 1,
  parameter logic [5:0]  MUL_OPCODE = 6'b011101
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [NW-1:0] opa,
  input  logic [NW-1:0] opb,
  input  logic [W-1:0]  alu_res,
  input  logic          alu_ovf,
  output logic          alu_en,
  output logic [5:0]    alu_opcode,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [W-1:0]  result,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Index of the final WAIT cycle, where the ALU output is valid.
  localparam logic [2:0] LatLast = 3'(ALU_LAT - 1);

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [NW-1:0] k_q, k_d;
  logic [NW-1:0] base_q, base_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [2:0]    lat_q, lat_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;

  // Number of multiplies a request needs, from the raw request operands.
  logic [NW-1:0] rem_start;

  // Work out the multiply count for a new request.
  always_comb begin
    rem_start = '0;
    if (!op) begin
      // 0! and 1! need no multiply at all.
      if (opa > NW'(1)) begin
        rem_start = opa - NW'(1);
      end
    end else begin
      rem_start = opb;
    end
  end

  // Next-state, datapath update and strobe generation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    k_d      = k_q;
    base_d   = base_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    alu_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = op;
          acc_d  = W'(1);
          ovf_d  = 1'b0;
          lat_d  = '0;
          base_d = opa;
          k_d    = op ? opb : opa;
          rem_d  = rem_start;
          // Trivial requests skip straight to DONE with acc = 1.
          state_d = (rem_start == '0) ? StDone : StIssue;
        end
      end

      StIssue: begin
        alu_en  = 1'b1;
        busy    = 1'b1;
        lat_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        busy = 1'b1;
        if (lat_q == LatLast) begin
          acc_d = alu_res;
          rem_d = rem_q - NW'(1);
          if (!op_q) begin
            k_d = k_q - NW'(1);
          end
          if (alu_ovf) begin
            // Stop on the first overflow; the truncated product is reported.
            ovf_d   = 1'b1;
            state_d = StDone;
          end else if (rem_q == NW'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      StDone: begin
        done     = 1'b1;
        result_d = acc_q;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      base_q   <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      base_q   <= base_d;
      rem_q    <= rem_d;
      lat_q    <= lat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operands are driven continuously; alu_en alone marks a valid issue.
  always_comb begin
    alu_opcode = MUL_OPCODE;
    alu_a      = acc_q;
    alu_b      = op_q ? W'(base_q) : W'(k_q);
    result     = result_q;
    ovf        = ovf_q;
  end

endmodule
